mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Owns the byte-addressable data memory. Performs byte/halfword/word loads with sign or zero extension, and lane-masked stores.
- Resolves the branch decision (pc_src) from EX/MEM branch and zero.
- Gives the debug unit a registered word-read port.
- After reset, zero-fills the memory with an internal clear sequencer before accepting any pipeline access.

---
 rtl/mem_access_stage_pkg.sv | 42 ++++
 rtl/mem_access_stage_if.sv | 36 +++
 rtl/mem_access_stage_data_memory_lanes.sv | 50 +++++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, clear-FSM states, default widths.
// Helper functions keep size priority and alignment rules in one place.
package mem_access_stage_pkg;

    localparam int NB_DATA_DEF  = 32;
    localparam int NB_WADDR_DEF = 7;

    typedef enum logic [1:0] {
        SIZE_NONE = 2'd0,
        SIZE_BYTE = 2'd1,
        SIZE_HALF = 2'd2,
        SIZE_WORD = 2'd3
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Word wins over halfword, halfword over byte.
    function automatic size_e decode_size(input logic byte_en,
                                          input logic half_en,
                                          input logic word_en);
        size_e s;
        if (word_en)      s = SIZE_WORD;
        else if (half_en) s = SIZE_HALF;
        else if (byte_en) s = SIZE_BYTE;
        else              s = SIZE_NONE;
        return s;
    endfunction

    function automatic logic is_misaligned(input size_e s, input logic [1:0] offset);
        logic m;
        case (s)
            SIZE_HALF: m = offset[0];
            SIZE_WORD: m = |offset;
            default:   m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM-side bus into the MEM stage plus its combinational results.
// slave = the stage itself, master = whoever drives the pipeline register outputs.
interface mem_access_stage_if #(
    parameter int NB_DATA = mem_access_stage_pkg::NB_DATA_DEF
);
    logic               i_pipeline_enable;
    logic               i_mem_read;
    logic               i_mem_write;
    logic               i_signed;
    logic               i_byte_enable;
    logic               i_halfword_enable;
    logic               i_word_enable;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] i_data_b;
    logic               i_branch;
    logic               i_zero;
    logic [NB_DATA-1:0] o_read_data;
    logic               o_pc_src;
    logic               o_misaligned;
    logic               o_fault;
    logic               o_ready;

    modport slave (
        input  i_pipeline_enable, i_mem_read, i_mem_write, i_signed,
        input  i_byte_enable, i_halfword_enable, i_word_enable,
        input  i_alu_result, i_data_b, i_branch, i_zero,
        output o_read_data, o_pc_src, o_misaligned, o_fault, o_ready
    );

    modport master (
        output i_pipeline_enable, i_mem_read, i_mem_write, i_signed,
        output i_byte_enable, i_halfword_enable, i_word_enable,
        output i_alu_result, i_data_b, i_branch, i_zero,
        input  o_read_data, o_pc_src, o_misaligned, o_fault, o_ready
    );
endinterface

// File: rtl/mem_access_stage_data_memory_lanes.sv
// Byte-lane-writable word RAM: async read port, registered debug read port.
// Debug read is read-before-write; contents are not reset (the stage clears them).
module data_memory_lanes #(
    parameter int NB_DATA  = mem_access_stage_pkg::NB_DATA_DEF,
    parameter int NB_WADDR = mem_access_stage_pkg::NB_WADDR_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_DATA/8-1:0]  i_lane_we,
    input  logic [NB_WADDR-1:0]   i_waddr,
    input  logic [NB_DATA-1:0]    i_wdata,
    input  logic [NB_WADDR-1:0]   i_raddr,
    output logic [NB_DATA-1:0]    o_rdata,
    input  logic                  i_dbg_rd,
    input  logic [NB_WADDR-1:0]   i_dbg_addr,
    output logic [NB_DATA-1:0]    o_dbg_data,
    output logic                  o_dbg_valid
);
    localparam int NB_LANES = NB_DATA / 8;
    localparam int DEPTH    = 2 ** NB_WADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [NB_DATA-1:0] r_dbg_data;
    logic               r_dbg_valid;

    always_ff @(posedge i_clock) begin
        for (int k = 0; k < NB_LANES; k++) begin
            if (i_lane_we[k]) begin
                r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_dbg_data  <= '0;
            r_dbg_valid <= 1'b0;
        end else begin
            r_dbg_valid <= i_dbg_rd;
            if (i_dbg_rd) begin
                r_dbg_data <= r_mem[i_dbg_addr];
            end
        end
    end

    assign o_rdata     = r_mem[i_raddr];
    assign o_dbg_data  = r_dbg_data;
    assign o_dbg_valid = r_dbg_valid;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: sized/extended loads, lane-masked stores, branch resolve, debug reads.
// Memory is zero-filled after reset; pipeline accesses are ignored until o_ready.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_WADDR = NB_WADDR_DEF,
    parameter int NB_REG   = 5
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    mem_access_stage_if.slave    bus,
    input  logic                 i_debug_rd,
    input  logic [NB_WADDR-1:0]  i_debug_addr,
    output logic [NB_DATA-1:0]   o_debug_data,
    output logic                 o_debug_valid
);
    localparam int NB_LANES = NB_DATA / 8;

    state_e                r_state;
    state_e                w_state_next;
    logic [NB_WADDR-1:0]   r_clr_cnt;
    logic [NB_WADDR-1:0]   w_clr_cnt_next;
    logic                  r_fault;

    logic [NB_WADDR-1:0]   w_word_idx;
    logic [1:0]            w_offset;
    size_e                 w_size;
    logic                  w_ready;
    logic                  w_misaligned;
    logic                  w_store;
    logic [NB_LANES-1:0]   w_lane_mask;
    logic [NB_DATA-1:0]    w_store_data;

    logic [NB_LANES-1:0]   w_mem_we;
    logic [NB_WADDR-1:0]   w_mem_waddr;
    logic [NB_DATA-1:0]    w_mem_wdata;
    logic [NB_DATA-1:0]    w_rword;
    logic [7:0]            w_rbyte;
    logic [15:0]           w_rhalf;
    logic [NB_DATA-1:0]    w_load_data;
    logic                  w_unused_ok;

    assign w_word_idx   = bus.i_alu_result[NB_WADDR+1:2];
    assign w_offset     = bus.i_alu_result[1:0];
    assign w_unused_ok  = &{1'b0, bus.i_alu_result[NB_DATA-1:NB_WADDR+2]};
    assign w_size       = decode_size(bus.i_byte_enable, bus.i_halfword_enable, bus.i_word_enable);
    assign w_ready      = (r_state == ST_RUN);
    assign w_misaligned = (bus.i_mem_read | bus.i_mem_write) & (w_size != SIZE_NONE)
                        & is_misaligned(w_size, w_offset);
    assign w_store      = bus.i_mem_write & bus.i_pipeline_enable & w_ready
                        & ~w_misaligned & (w_size != SIZE_NONE);

    // Store data is replicated across lanes so the lane mask alone picks the target bytes.
    always_comb begin
        w_lane_mask  = '0;
        w_store_data = bus.i_data_b;
        case (w_size)
            SIZE_BYTE: begin
                w_lane_mask  = NB_LANES'(1) << w_offset;
                w_store_data = {NB_LANES{bus.i_data_b[7:0]}};
            end
            SIZE_HALF: begin
                w_lane_mask  = w_offset[1] ? 4'b1100 : 4'b0011;
                w_store_data = {(NB_LANES/2){bus.i_data_b[15:0]}};
            end
            SIZE_WORD: begin
                w_lane_mask  = '1;
            end
            default: ;
        endcase
    end

    // Clear FSM: next state and the memory write-port mux.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_mem_we       = '0;
        w_mem_waddr    = w_word_idx;
        w_mem_wdata    = w_store_data;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we       = '1;
                w_mem_waddr    = r_clr_cnt;
                w_mem_wdata    = '0;
                w_clr_cnt_next = r_clr_cnt + NB_WADDR'(1);
                if (r_clr_cnt == {NB_WADDR{1'b1}}) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_mem_we = w_store ? w_lane_mask : '0;
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            if (w_misaligned & bus.i_pipeline_enable & w_ready) begin
                r_fault <= 1'b1;
            end
        end
    end

    data_memory_lanes #(
        .NB_DATA  (NB_DATA),
        .NB_WADDR (NB_WADDR)
    ) u_mem (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_lane_we   (w_mem_we),
        .i_waddr     (w_mem_waddr),
        .i_wdata     (w_mem_wdata),
        .i_raddr     (w_word_idx),
        .o_rdata     (w_rword),
        .i_dbg_rd    (i_debug_rd & w_ready),
        .i_dbg_addr  (i_debug_addr),
        .o_dbg_data  (o_debug_data),
        .o_dbg_valid (o_debug_valid)
    );

    assign w_rbyte = w_rword[{w_offset, 3'b000} +: 8];
    assign w_rhalf = w_offset[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load_data = '0;
        if (w_ready & bus.i_mem_read & ~w_misaligned) begin
            case (w_size)
                SIZE_BYTE: w_load_data = {{(NB_DATA-8){bus.i_signed & w_rbyte[7]}}, w_rbyte};
                SIZE_HALF: w_load_data = {{(NB_DATA-16){bus.i_signed & w_rhalf[15]}}, w_rhalf};
                SIZE_WORD: w_load_data = w_rword;
                default:   w_load_data = '0;
            endcase
        end
    end

    assign bus.o_read_data  = w_load_data;
    assign bus.o_pc_src     = bus.i_branch & bus.i_zero;
    assign bus.o_misaligned = w_misaligned;
    assign bus.o_fault      = r_fault;
    assign bus.o_ready      = w_ready;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: clear sequence, loads/stores, faults, debug port.
module tb_mem_access_stage;
    logic        i_clock;
    logic        i_reset;
    logic        i_debug_rd;
    logic [6:0]  i_debug_addr;
    logic [31:0] o_debug_data;
    logic        o_debug_valid;
    int          checks;
    int          failures;
    int          n;

    mem_access_stage_if #(.NB_DATA(32)) bus ();

    mem_access_stage #(.NB_DATA(32), .NB_WADDR(7), .NB_REG(5)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .bus           (bus),
        .i_debug_rd    (i_debug_rd),
        .i_debug_addr  (i_debug_addr),
        .o_debug_data  (o_debug_data),
        .o_debug_valid (o_debug_valid)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle();
        bus.i_mem_read        = 1'b0;
        bus.i_mem_write       = 1'b0;
        bus.i_signed          = 1'b0;
        bus.i_byte_enable     = 1'b0;
        bus.i_halfword_enable = 1'b0;
        bus.i_word_enable     = 1'b0;
        bus.i_pipeline_enable = 1'b1;
    endtask

    task automatic set_size(input logic b, input logic h, input logic w);
        bus.i_byte_enable     = b;
        bus.i_halfword_enable = h;
        bus.i_word_enable     = w;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic b, input logic h, input logic w, input logic pe);
        idle();
        set_size(b, h, w);
        bus.i_mem_write       = 1'b1;
        bus.i_alu_result      = addr;
        bus.i_data_b          = data;
        bus.i_pipeline_enable = pe;
        tick();
        idle();
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic sgn,
                        input logic b, input logic h, input logic w, input logic [31:0] exp);
        idle();
        set_size(b, h, w);
        bus.i_mem_read   = 1'b1;
        bus.i_signed     = sgn;
        bus.i_alu_result = addr;
        #1;
        check(tag, bus.o_read_data, exp);
        idle();
    endtask

    task automatic dbg(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        i_debug_rd   = 1'b1;
        i_debug_addr = addr;
        tick();
        check({tag, "_valid"}, {31'd0, o_debug_valid}, 32'd1);
        check(tag, o_debug_data, exp);
        i_debug_rd = 1'b0;
        tick();
        check({tag, "_drop"}, {31'd0, o_debug_valid}, 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        i_reset      = 1'b0;
        i_debug_rd   = 1'b0;
        i_debug_addr = '0;
        bus.i_alu_result = '0;
        bus.i_data_b     = '0;
        bus.i_branch     = 1'b0;
        bus.i_zero       = 1'b0;
        idle();

        repeat (3) tick();
        check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
        check("rst_fault", {31'd0, bus.o_fault}, 32'd0);
        check("rst_dvalid", {31'd0, o_debug_valid}, 32'd0);
        check("rst_ddata", o_debug_data, 32'd0);

        // Interrupted clear: reset again at count 50
        i_reset = 1'b1;
        repeat (50) tick();
        check("clr50_ready", {31'd0, bus.o_ready}, 32'd0);
        i_reset = 1'b0;
        #2;
        check("midrst_ready", {31'd0, bus.o_ready}, 32'd0);
        i_reset = 1'b1;

        bus.i_branch = 1'b1;
        bus.i_zero   = 1'b1;
        i_debug_rd   = 1'b1;
        i_debug_addr = 7'd3;
        bus.i_mem_write  = 1'b1;
        bus.i_mem_read   = 1'b1;
        bus.i_word_enable = 1'b1;
        bus.i_alu_result = 32'h0000_0040;
        bus.i_data_b     = 32'hCAFE_F00D;
        #1;
        check("pcsrc_clear", {31'd0, bus.o_pc_src}, 32'd1);
        n = 0;
        while (!bus.o_ready && n < 300) begin
            tick();
            n++;
            if (n == 5) begin
                check("clear_dvalid", {31'd0, o_debug_valid}, 32'd0);
                check("clear_load", bus.o_read_data, 32'd0);
            end
        end
        check("clear_cycles", n, 32'd128);
        i_debug_rd = 1'b0;
        idle();
        bus.i_branch = 1'b0;
        #1;
        check("pcsrc_b0", {31'd0, bus.o_pc_src}, 32'd0);

        dbg("dbg_w0", 7'd0, 32'd0);
        dbg("dbg_w64", 7'd64, 32'd0);
        dbg("dbg_w127", 7'd127, 32'd0);
        load("clear_store_dropped", 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

        // Sized loads with extension
        store(32'h10, 32'h8000_F0A5, 1'b0, 1'b0, 1'b1, 1'b1);
        load("lw_10",   32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_F0A5);
        load("lb_s_10", 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFA5);
        load("lbu_11",  32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00F0);
        load("lhu_12",  32'h12, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_8000);
        load("lh_s_12", 32'h12, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_8000);
        load("prio_wd", 32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_F0A5);
        load("no_size", 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        load("wrap_lw", 32'h210, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_F0A5);

        // Byte store lane masking and pipeline freeze
        store(32'h20, 32'h1122_3344, 1'b0, 1'b0, 1'b1, 1'b1);
        store(32'h23, 32'hAAAA_AA7E, 1'b1, 1'b0, 1'b0, 1'b0);
        load("sb_frozen", 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1122_3344);
        store(32'h23, 32'hAAAA_AA7E, 1'b1, 1'b0, 1'b0, 1'b1);
        load("sb_13", 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7E22_3344);
        store(32'h22, 32'h5555_BEEF, 1'b0, 1'b1, 1'b0, 1'b1);
        load("sh_hi", 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_3344);

        // Misaligned halfword store
        check("fault_pre", {31'd0, bus.o_fault}, 32'd0);
        idle();
        set_size(1'b0, 1'b1, 1'b0);
        bus.i_mem_write  = 1'b1;
        bus.i_alu_result = 32'h11;
        bus.i_data_b     = 32'h0000_1234;
        #1;
        check("mis_sh", {31'd0, bus.o_misaligned}, 32'd1);
        tick();
        idle();
        check("fault_set", {31'd0, bus.o_fault}, 32'd1);
        load("mis_unchanged", 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_F0A5);
        tick();
        check("fault_sticky", {31'd0, bus.o_fault}, 32'd1);
        load("lw_mis_22", 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        idle();
        set_size(1'b0, 1'b0, 1'b1);
        bus.i_mem_read   = 1'b1;
        bus.i_alu_result = 32'h22;
        #1;
        check("mis_lw", {31'd0, bus.o_misaligned}, 32'd1);
        bus.i_mem_read = 1'b0;
        #1;
        check("mis_noacc", {31'd0, bus.o_misaligned}, 32'd0);
        idle();

        // Simultaneous read and write
        set_size(1'b0, 1'b0, 1'b1);
        bus.i_mem_read   = 1'b1;
        bus.i_mem_write  = 1'b1;
        bus.i_alu_result = 32'h30;
        bus.i_data_b     = 32'h1234_5678;
        #1;
        check("rw_old", bus.o_read_data, 32'd0);
        tick();
        bus.i_mem_write = 1'b0;
        #1;
        check("rw_new", bus.o_read_data, 32'h1234_5678);
        idle();

        // Debug read-before-write, then with pipeline frozen
        set_size(1'b0, 1'b0, 1'b1);
        bus.i_mem_write  = 1'b1;
        bus.i_alu_result = 32'h10;
        bus.i_data_b     = 32'hDEAD_BEEF;
        i_debug_rd       = 1'b1;
        i_debug_addr     = 7'd4;
        tick();
        idle();
        check("dbg_rbw", o_debug_data, 32'h8000_F0A5);
        bus.i_pipeline_enable = 1'b0;
        tick();
        check("dbg_hold_valid", {31'd0, o_debug_valid}, 32'd1);
        check("dbg_new", o_debug_data, 32'hDEAD_BEEF);
        i_debug_rd = 1'b0;
        tick();
        check("dbg_drop", {31'd0, o_debug_valid}, 32'd0);
        idle();
        dbg("dbg_w8", 7'd8, 32'hBEEF_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
